uart_alu_ctrl: RTL and testbench

- Command sequencer between the UART receiver, an external combinational ALU and the UART transmitter.
- Collects three received bytes in order: operand A, operand B, opcode.
- Drives the ALU with the captured values, registers the result, and hands it to the transmitter with a start/done handshake.
- Returns to waiting for the next command frame.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_timeout_cnt.sv | 30 +++
 rtl/uart_alu_ctrl.sv | 118 +++++++++++
 tb/tb_uart_alu_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and opcode constants for the UART/ALU command path.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } ctrl_state_t;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte timeout counter: clears on request, counts while enabled,
// flags the cycle in which it sits at TIMEOUT_CYCLES-1.
module uart_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Command sequencer: collects A, B, opcode bytes, runs the external ALU and
// hands the result to the transmitter. Optional timeout: UART_CTRL_TIMEOUT_EN.
//
// state   | meaning
// WAIT_A  | idle, next rx byte is operand A
// WAIT_B  | next rx byte is operand B
// WAIT_OP | next rx byte is the opcode
// EXEC    | ALU inputs stable, capture result
// SEND    | tx_start high for this cycle
// WAIT_TX | waiting for tx_done from the transmitter
module uart_alu_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int OP_W           = 6,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              busy,
    output logic              err_overrun,
    output logic              err_timeout
);

    ctrl_state_t state;
    logic        tmo_expired;
    logic        rx_blocked;

    assign busy       = (state != WAIT_A);
    assign rx_blocked = (state == EXEC) || (state == SEND) || (state == WAIT_TX);

`ifdef UART_CTRL_TIMEOUT_EN
    logic tmo_wait;
    assign tmo_wait = (state == WAIT_B) || (state == WAIT_OP);

    uart_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_valid || !tmo_wait),
        .enable (tmo_wait),
        .expired(tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_A;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= rx_valid && rx_blocked;
            case (state)
                WAIT_A: begin
                    if (rx_valid) begin
                        alu_a <= rx_data;
                        state <= WAIT_B;
                    end
                end
                // an arriving byte beats a timeout firing in the same cycle
                WAIT_B: begin
                    if (rx_valid) begin
                        alu_b <= rx_data;
                        state <= WAIT_OP;
                    end else if (tmo_expired) begin
                        err_timeout <= 1'b1;
                        state       <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (rx_valid) begin
                        alu_op <= rx_data[OP_W-1:0];
                        state  <= EXEC;
                    end else if (tmo_expired) begin
                        err_timeout <= 1'b1;
                        state       <= WAIT_A;
                    end
                end
                EXEC: begin
                    tx_data  <= alu_result;
                    tx_start <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        state <= WAIT_A;
                    end
                end
                default: begin
                    state <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: vector table, corner sequences and
// randomized frames against a behavioural ALU/frame model.
module tb_uart_alu_ctrl;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] alu_a, alu_b, alu_result, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, tx_done, busy, err_overrun, err_timeout;

    int checks = 0;
    int errors = 0;
    int ov_seen = 0;
    int ov_exp = 0;
    int tmo_seen = 0;

    uart_alu_ctrl #(
        .DATA_W(8),
        .OP_W(6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_op(alu_op),
        .alu_result(alu_result),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_done(tx_done),
        .busy(busy),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRL:  return a >> b[2:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[2:0]);
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_a, alu_b, alu_op);

    always @(posedge clk) begin
        if (err_overrun) ov_seen++;
        if (err_timeout) tmo_seen++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_overrun"}, err_overrun, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    // Full frame: three bytes, result check on the tx_start cycle, optional
    // overrun byte while waiting for the transmitter, then tx_done.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                             input logic [7:0] exp_res, input logic [5:0] exp_op,
                             input int gap_max, input bit inject_ov, input string tag);
        send_byte(a);
        idle($urandom_range(0, gap_max));
        send_byte(b);
        idle($urandom_range(0, gap_max));
        send_byte(opb);
        chk({tag, "_alu_a"}, alu_a, a);
        chk({tag, "_alu_b"}, alu_b, b);
        chk({tag, "_alu_op"}, alu_op, exp_op);
        chk({tag, "_start_early"}, tx_start, 0);
        tick();
        chk({tag, "_tx_start"}, tx_start, 1);
        chk({tag, "_tx_data"}, tx_data, exp_res);
        tick();
        chk({tag, "_start_width"}, tx_start, 0);
        chk({tag, "_busy_wait_tx"}, busy, 1);
        if (inject_ov) begin
            send_byte(8'hAA);
            ov_exp++;
            chk({tag, "_ovr_pulse"}, err_overrun, 1);
            chk({tag, "_ovr_alu_a"}, alu_a, a);
            chk({tag, "_ovr_busy"}, busy, 1);
        end
        idle($urandom_range(0, gap_max));
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({tag, "_done_busy"}, busy, 0);
        chk({tag, "_tx_data_hold"}, tx_data, exp_res);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [7:0] exp_res;
        logic [5:0] exp_op;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [5:0] ops[8];
        logic [7:0] a, b, opb;
        bit         hold_ok;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 6'h20};
        vecs[1] = '{8'hF0, 8'h0F, 8'h25, 8'hFF, 6'h25};
        vecs[2] = '{8'h80, 8'h01, 8'h22, 8'h7F, 6'h22};
        vecs[3] = '{8'h10, 8'h20, 8'hE0, 8'h30, 6'h20};
        vecs[4] = '{8'hF0, 8'h0F, 8'h24, 8'h00, 6'h24};
        vecs[5] = '{8'hC3, 8'h3C, 8'h26, 8'hFF, 6'h26};
        vecs[6] = '{8'h0F, 8'hF0, 8'h27, 8'h00, 6'h27};
        vecs[7] = '{8'hFF, 8'h01, 8'h20, 8'h00, 6'h20};
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_done  = 1'b0;
        idle(3);
        reset = 1'b0;
        check_reset_state("por");

        // back-to-back table frames, no gaps
        for (int i = 0; i < 8; i++)
            run_frame(vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].exp_res, vecs[i].exp_op,
                      0, 1'b0, $sformatf("vec%0d", i));
        chk("vec_no_overrun", ov_seen, 0);

        // overrun while waiting for the transmitter
        run_frame(8'h11, 8'h22, 8'h20, 8'h33, 6'h20, 1, 1'b1, "ovr_wait_tx");

        // overrun during EXEC: byte arrives right after the opcode
        send_byte(8'h07);
        send_byte(8'h02);
        send_byte(8'h22);
        send_byte(8'h5A);
        ov_exp++;
        chk("ovr_exec_pulse", err_overrun, 1);
        chk("ovr_exec_tx_data", tx_data, 8'h05);
        chk("ovr_exec_start", tx_start, 1);
        tick();
        chk("ovr_exec_alu_a", alu_a, 8'h07);
        // simultaneous tx_done and rx_valid: state returns idle, byte dropped
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        tx_done  = 1'b1;
        tick();
        rx_valid = 1'b0;
        tx_done  = 1'b0;
        ov_exp++;
        chk("simul_busy", busy, 0);
        chk("simul_ovr", err_overrun, 1);
        chk("simul_alu_a", alu_a, 8'h07);
        tick();
        chk("simul_ovr_width", err_overrun, 0);

        // reset in WAIT_OP, stale tx_done ignored, then a fresh frame
        send_byte(8'h44);
        send_byte(8'h55);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("rst_wait_op");
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("rst_tx_done_busy", busy, 0);
        chk("rst_tx_done_start", tx_start, 0);
        run_frame(8'h05, 8'h03, 8'h20, 8'h08, 6'h20, 0, 1'b0, "post_rst");

        // reset while waiting for tx_done
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h20);
        idle(2);
        chk("pre_rst2_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("rst_wait_tx");

        // randomized frames against the model
        for (int i = 0; i < 150; i++) begin
            bit ov;
            logic [5:0] op;
            a   = 8'($urandom);
            b   = 8'($urandom);
            op  = ops[$urandom_range(0, 7)];
            opb = {2'($urandom), op};
            ov  = ($urandom_range(0, 3) == 0);
            run_frame(a, b, opb, alu_model(a, b, op), op, 3, ov, $sformatf("rnd%0d", i));
        end
        chk("overrun_count", ov_seen, ov_exp);
        chk("timeout_count_idle", tmo_seen, 0);

`ifdef UART_CTRL_TIMEOUT_EN
        // one byte then silence: timeout fires 16 cycles later
        send_byte(8'h3C);
        idle(15);
        chk("tmo_not_early", err_timeout, 0);
        chk("tmo_busy_before", busy, 1);
        tick();
        chk("tmo_pulse", err_timeout, 1);
        chk("tmo_busy_after", busy, 0);
        chk("tmo_alu_a_kept", alu_a, 8'h3C);
        tick();
        chk("tmo_pulse_width", err_timeout, 0);
        // byte arriving in the firing cycle is captured instead
        send_byte(8'h12);
        idle(15);
        send_byte(8'h34);
        chk("tmo_race_no_pulse", err_timeout, 0);
        chk("tmo_race_alu_b", alu_b, 8'h34);
        chk("tmo_race_busy", busy, 1);
        idle(15);
        send_byte(8'h20);
        chk("tmo_race_op", alu_op, 6'h20);
        tick();
        chk("tmo_race_start", tx_start, 1);
        chk("tmo_race_result", tx_data, 8'h46);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("tmo_race_done", busy, 0);
`else
        // without the timeout the FSM waits indefinitely
        send_byte(8'h3C);
        hold_ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (!busy || err_timeout) hold_ok = 1'b0;
            tick();
        end
        chk("no_tmo_busy_held", hold_ok, 1);
        chk("no_tmo_alu_a", alu_a, 8'h3C);
        chk("no_tmo_count", tmo_seen, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
